// File: rtl/if_id_pkg.sv
// ============================================================================
// Module  : if_id_pkg
// Purpose : Shared next-PC op encodings, reset constants and fetch FSM states
//           for the IF/ID stage.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package if_id_pkg;

    localparam logic [2:0]  NPC_PLUS4  = 3'b000;
    localparam logic [2:0]  NPC_BRANCH = 3'b001;
    localparam logic [2:0]  NPC_JAL    = 3'b010;
    localparam logic [2:0]  NPC_JALR   = 3'b100;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } if_state_e;

endpackage : if_id_pkg

`default_nettype wire

// File: rtl/if_id_stage_npc_sel.sv
// ============================================================================
// Module  : npc_sel
// Purpose : Combinational next-PC mux; jalr beats jal beats branch beats PC+4.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module npc_sel
    import if_id_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_npc_op,
    input  logic [31:0] i_br_target,
    input  logic [31:0] i_jalr_target,
    output logic [31:0] o_next_pc,
    output logic        o_redirect
);

    logic [31:0] w_jalr_aligned;

    assign w_jalr_aligned = i_jalr_target & ~32'h0000_0001;
    assign o_redirect     = (i_npc_op != NPC_PLUS4);

    always_comb begin
        o_next_pc = i_pc + 32'd4;
        if (i_npc_op[2]) begin
            o_next_pc = w_jalr_aligned;
        end else if (i_npc_op[1] || i_npc_op[0]) begin
            o_next_pc = i_br_target;
        end
    end

endmodule : npc_sel

`default_nettype wire

// File: rtl/if_id_stage.sv
// ============================================================================
// Module  : if_id_stage
// Purpose : Fetch PC register plus IF/ID pipeline register feeding decode.
//           Optional perf counters enabled by defining IFID_PERF_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_stage #(
    parameter logic [31:0] RESET_PC  = if_id_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = if_id_pkg::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       NPCOp,
    input  logic [31:0]      br_target,
    input  logic [31:0]      jalr_target,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      imem_addr,
    output logic [31:0]      IF_IDpc,
    output logic [31:0]      IF_IDinstr,
    output logic             IF_IDvalid,
    output logic [4:0]       IF_IDrs1,
    output logic [4:0]       IF_IDrs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import if_id_pkg::*;

    if_state_e   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic [31:0] w_next_pc;
    logic        w_redirect;

    npc_sel u_npc_sel (
        .i_pc          (r_pc),
        .i_npc_op      (NPCOp),
        .i_br_target   (br_target),
        .i_jalr_target (jalr_target),
        .o_next_pc     (w_next_pc),
        .o_redirect    (w_redirect)
    );

    // Redirect outranks stall: the hazard unit stalls on a taken branch too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_redirect) begin
                        r_pc         <= w_next_pc;
                        r_ifid_instr <= NOP_INSTR;
                        r_ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        r_pc         <= w_next_pc;
                        r_ifid_pc    <= r_pc;
                        r_ifid_instr <= imem_instr;
                        r_ifid_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign IF_IDpc    = r_ifid_pc;
    assign IF_IDinstr = r_ifid_instr;
    assign IF_IDvalid = r_ifid_valid;
    assign IF_IDrs1   = r_ifid_instr[19:15];
    assign IF_IDrs2   = r_ifid_instr[24:20];

`ifdef IFID_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (w_redirect) begin
                if (r_flush_cnt != {CNT_W{1'b1}}) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
            end else if (stall) begin
                if (r_stall_cnt != {CNT_W{1'b1}}) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule : if_id_stage

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module  : tb_if_id_stage
// Purpose : Self-checking bench for if_id_stage against a behavioural model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage;

    localparam int          CNT_W = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [2:0]       NPCOp;
    logic [31:0]      br_target;
    logic [31:0]      jalr_target;
    logic [31:0]      imem_instr;
    logic [31:0]      imem_addr;
    logic [31:0]      IF_IDpc;
    logic [31:0]      IF_IDinstr;
    logic             IF_IDvalid;
    logic [4:0]       IF_IDrs1;
    logic [4:0]       IF_IDrs2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    if_id_stage #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .NPCOp       (NPCOp),
        .br_target   (br_target),
        .jalr_target (jalr_target),
        .imem_instr  (imem_instr),
        .imem_addr   (imem_addr),
        .IF_IDpc     (IF_IDpc),
        .IF_IDinstr  (IF_IDinstr),
        .IF_IDvalid  (IF_IDvalid),
        .IF_IDrs1    (IF_IDrs1),
        .IF_IDrs2    (IF_IDrs2),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words, a hash of the address elsewhere.
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
    endfunction

    assign imem_instr = imem_f(imem_addr);

    // Reference model state
    bit          m_boot;
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic        m_valid;
    longint      m_stalls, m_flushes;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [CNT_W-1:0] sat(input longint v);
        longint maxv = (longint'(1) << CNT_W) - 1;
        return (v > maxv) ? CNT_W'(maxv) : CNT_W'(v);
    endfunction

    task automatic model_reset();
        m_boot = 1; m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_valid = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_edge();
        if (m_boot) begin
            m_boot = 0;
        end else if (NPCOp != 3'b000) begin
            m_pc      = NPCOp[2] ? {jalr_target[31:1], 1'b0} : br_target;
            m_instr   = NOP;
            m_valid   = 0;
            m_flushes = m_flushes + 1;
        end else if (stall) begin
            m_stalls = m_stalls + 1;
        end else begin
            m_ifpc  = m_pc;
            m_instr = imem_f(m_pc);
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [CNT_W-1:0] es, ef;
`ifdef IFID_PERF_EN
        es = sat(m_stalls);
        ef = sat(m_flushes);
`else
        es = '0;
        ef = '0;
`endif
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".pc"},        IF_IDpc, m_ifpc);
        chk({tag, ".instr"},     IF_IDinstr, m_instr);
        chk({tag, ".valid"},     32'(IF_IDvalid), 32'(m_valid));
        chk({tag, ".rs1"},       32'(IF_IDrs1), 32'(m_instr[19:15]));
        chk({tag, ".rs2"},       32'(IF_IDrs2), 32'(m_instr[24:20]));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(es));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(ef));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic s, input logic [2:0] op,
                         input logic [31:0] br, input logic [31:0] jr);
        stall = s; NPCOp = op; br_target = br; jalr_target = jr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst = 1'b0;

        // Boot edge ignores stall/NPCOp
        drive(1'b1, 3'b001, 32'h1234, 32'h0);
        tick("boot");
        chk("boot.addr_fixed", imem_addr, 32'h0);

        // Sequential fetch
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick("seq0");
        chk("seq0.pc_lit", IF_IDpc, 32'h0);
        chk("seq0.instr_lit", IF_IDinstr, 32'h00A0_0093);
        tick("seq1");
        chk("seq1.pc_lit", IF_IDpc, 32'h4);
        chk("seq1.addr_lit", imem_addr, 32'h8);

        // Stall two cycles at PC=8
        drive(1'b1, 3'b000, 32'h0, 32'h0);
        tick("stall0");
        tick("stall1");
        chk("stall.addr_lit", imem_addr, 32'h8);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick("unstall");
        chk("unstall.addr_lit", imem_addr, 32'hC);

        // Branch redirect overriding stall
        drive(1'b1, 3'b001, 32'h40, 32'h0);
        tick("branch");
        chk("branch.addr_lit", imem_addr, 32'h40);
        chk("branch.instr_lit", IF_IDinstr, 32'h13);

        // jalr with jal bit also set: jalr wins, bit 0 cleared
        drive(1'b0, 3'b101, 32'h20, 32'h81);
        tick("jalr");
        chk("jalr.addr_lit", imem_addr, 32'h80);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick("jalr_next");
        chk("jalr_next.pc_lit", IF_IDpc, 32'h80);

        // Jal-only redirect
        drive(1'b0, 3'b010, 32'h200, 32'h333);
        tick("jal");

        // Randomized run
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            drive(($urandom_range(0, 3) == 0), op,
                  $urandom & 32'hFFFF_FFFC, $urandom);
            tick("rand");
        end

        // Asynchronous reset pulse between edges
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        tick("reboot");

        // PC+4 wraps at the top of the address space
        drive(1'b0, 3'b100, 32'h0, 32'hFFFF_FFFD);
        tick("to_top");
        chk("to_top.addr_lit", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick("wrap");
        chk("wrap.addr_lit", imem_addr, 32'h0);
        chk("wrap.pc_lit", IF_IDpc, 32'hFFFF_FFFC);
        tick("after_wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_if_id_stage

`default_nettype wire
